// File: rtl/gtech_skid_buf.sv
// gtech_skid_buf: two-entry valid/ready skid buffer feeding a GTECH flop stage.
// The main register drives Q/QN; the skid register catches the one word that
// can arrive while the consumer stalls. DR depends on state (and RST) only, so
// there is no combinational path from QR to DR.
module gtech_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             CP,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  output logic             DR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             QV,
  input  logic             QR,
  output logic [1:0]       OCC
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             push;
  logic             pop;

  // Handshake outputs are derived from state so the downstream stall never
  // ripples combinationally back to the producer.
  assign DR   = (state_q != FULL) & ~RST;
  assign QV   = (state_q != EMPTY);
  assign Q    = main_q;
  assign QN   = ~main_q;
  assign OCC  = state_q;
  assign push = DV & DR;
  assign pop  = QV & QR;

  // Next-state and datapath steering for the main/skid register pair.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (FLUSH) begin
      // Push in this cycle is dropped; a pop has already been seen downstream.
      state_d = EMPTY;
      main_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            main_d  = D;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = D;
          end else if (push) begin
            skid_d  = D;
            state_d = FULL;
          end else if (pop) begin
            // main keeps its stale value; Q is ignored while QV is low.
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and data registers with synchronous reset having top priority.
  always_ff @(posedge CP) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // computed for this edge, independent of statement order.
    if (RST) begin
      // NOTE: both data registers are reset, not just the state, so Q reads
      // zero out of reset and no pre-reset word can leak through.
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_gtech_skid_buf.sv
// Self-checking bench for gtech_skid_buf: directed scenarios plus a randomized
// run checked against a queue-based model of a two-entry FIFO.
module tb_gtech_skid_buf;

  localparam int WIDTH = 8;

  logic             CP = 1'b0;
  logic             RST = 1'b1;
  logic             FLUSH = 1'b0;
  logic [WIDTH-1:0] D = '0;
  logic             DV = 1'b0;
  logic             DR;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] QN;
  logic             QV;
  logic             QR = 1'b0;
  logic [1:0]       OCC;

  int checks = 0;
  int failures = 0;

  // Reference model: contents of the buffer as a queue, plus whether Q is
  // known to be zero (after reset/flush and before any new word arrives).
  logic [WIDTH-1:0] mq[$];
  bit               m_zero = 1'b1;
  logic [WIDTH-1:0] exp_popped[$];
  logic [WIDTH-1:0] dut_popped[$];

  gtech_skid_buf #(.WIDTH(WIDTH)) dut (
    .CP(CP), .RST(RST), .FLUSH(FLUSH), .D(D), .DV(DV), .DR(DR),
    .Q(Q), .QN(QN), .QV(QV), .QR(QR), .OCC(OCC)
  );

  always #5 CP = ~CP;

  // Drive one cycle of inputs, advance one edge, update the model, and leave
  // time at 1 unit after the edge so outputs are sampled away from it.
  task automatic step(input bit rst, input bit flush, input bit dv,
                      input logic [WIDTH-1:0] d, input bit qr);
    bit m_push;
    bit m_pop;
    RST = rst; FLUSH = flush; DV = dv; D = d; QR = qr;
    if (!rst && QV && qr) dut_popped.push_back(Q);
    @(posedge CP);
    if (rst) begin
      mq.delete();
      m_zero = 1'b1;
    end else begin
      m_pop  = (mq.size() > 0) && qr;
      m_push = dv && (mq.size() < 2);
      if (m_pop) exp_popped.push_back(mq.pop_front());
      if (flush) begin
        mq.delete();
        m_zero = 1'b1;
      end else if (m_push) begin
        mq.push_back(d);
        m_zero = 1'b0;
      end
    end
    #1;
  endtask

  task automatic clear_logs();
    exp_popped.delete();
    dut_popped.delete();
  endtask

  task automatic test_reset();
    step(1, 0, 1, 8'hAA, 0);
    step(1, 0, 1, 8'hAA, 0);
    RST = 1'b0; DV = 1'b0; #1;
    checks++; if (Q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", Q); end
    checks++; if (QN !== 8'hFF) begin failures++; $display("FAIL reset_qn got=%h exp=ff", QN); end
    checks++; if (QV !== 1'b0) begin failures++; $display("FAIL reset_qv got=%b exp=0", QV); end
    checks++; if (DR !== 1'b1) begin failures++; $display("FAIL reset_dr got=%b exp=1", DR); end
    checks++; if (OCC !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", OCC); end
    step(0, 0, 0, 8'h00, 1);
    checks++; if (QV !== 1'b0 || dut_popped.size() != 0) begin
      failures++; $display("FAIL reset_no_emit qv=%b popped=%0d exp qv=0 popped=0", QV, dut_popped.size());
    end
    clear_logs();
  endtask

  task automatic test_single_pass();
    step(0, 0, 1, 8'h3C, 1);
    checks++; if (Q !== 8'h3C || QN !== 8'hC3 || QV !== 1'b1) begin
      failures++; $display("FAIL single_present q=%h qn=%h qv=%b exp 3c c3 1", Q, QN, QV);
    end
    step(0, 0, 0, 8'h00, 1);
    checks++; if (OCC !== 2'd0 || QV !== 1'b0) begin
      failures++; $display("FAIL single_pop occ=%0d qv=%b exp 0 0", OCC, QV);
    end
    checks++; if (dut_popped.size() != 1 || dut_popped[0] !== 8'h3C) begin
      failures++; $display("FAIL single_word popped=%0d exp one word 3c", dut_popped.size());
    end
    clear_logs();
  endtask

  task automatic test_stall_fill();
    logic [WIDTH-1:0] want[3];
    want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33;
    step(0, 0, 1, 8'h11, 0);
    step(0, 0, 1, 8'h22, 0);
    checks++; if (OCC !== 2'd2 || DR !== 1'b0 || Q !== 8'h11) begin
      failures++; $display("FAIL stall_full occ=%0d dr=%b q=%h exp 2 0 11", OCC, DR, Q);
    end
    step(0, 0, 1, 8'h33, 0);
    checks++; if (OCC !== 2'd2 || Q !== 8'h11) begin
      failures++; $display("FAIL stall_hold occ=%0d q=%h exp 2 11", OCC, Q);
    end
    step(0, 0, 1, 8'h33, 1);   // pops 11; 33 refused since DR was 0
    step(0, 0, 1, 8'h33, 1);   // pops 22, accepts 33
    step(0, 0, 0, 8'h00, 1);   // pops 33
    checks++; if (dut_popped.size() != 3) begin
      failures++; $display("FAIL stall_count got=%0d exp=3", dut_popped.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (dut_popped[i] !== want[i]) begin
          failures++; $display("FAIL stall_order idx=%0d got=%h exp=%h", i, dut_popped[i], want[i]);
        end
      end
    end
    clear_logs();
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, WIDTH'(i), 1);
      checks++; if (Q !== WIDTH'(i) || OCC !== 2'd1 || DR !== 1'b1 || QV !== 1'b1) begin
        failures++; $display("FAIL stream_cycle i=%0d q=%h occ=%0d dr=%b qv=%b exp q=%h occ=1 dr=1 qv=1",
                             i, Q, OCC, DR, QV, WIDTH'(i));
      end
    end
    step(0, 0, 0, 8'h00, 1);
    checks++; if (dut_popped.size() != 16) begin
      failures++; $display("FAIL stream_count got=%0d exp=16", dut_popped.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (dut_popped[i] !== WIDTH'(i)) begin
          failures++; $display("FAIL stream_order idx=%0d got=%h exp=%h", i, dut_popped[i], WIDTH'(i));
        end
      end
    end
    clear_logs();
  endtask

  task automatic test_flush();
    step(0, 0, 1, 8'h55, 0);
    step(0, 0, 1, 8'h66, 0);
    step(0, 1, 1, 8'h77, 0);
    checks++; if (OCC !== 2'd0 || QV !== 1'b0 || Q !== 8'h00 || QN !== 8'hFF) begin
      failures++; $display("FAIL flush_state occ=%0d qv=%b q=%h qn=%h exp 0 0 00 ff", OCC, QV, Q, QN);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 1);
    checks++; if (QV !== 1'b0 || dut_popped.size() != 0) begin
      failures++; $display("FAIL flush_no_emit qv=%b popped=%0d exp qv=0 popped=0", QV, dut_popped.size());
    end
    clear_logs();
  endtask

  task automatic test_reset_mid();
    step(0, 0, 1, 8'hA1, 0);
    step(0, 0, 1, 8'hA2, 0);
    step(1, 0, 1, 8'h99, 0);
    checks++; if (OCC !== 2'd0 || QV !== 1'b0) begin
      failures++; $display("FAIL rstmid_state occ=%0d qv=%b exp 0 0", OCC, QV);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 1);
    checks++; if (QV !== 1'b0 || Q !== 8'h00 || dut_popped.size() != 0) begin
      failures++; $display("FAIL rstmid_no_emit qv=%b q=%h popped=%0d exp 0 00 0", QV, Q, dut_popped.size());
    end
    clear_logs();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 70), WIDTH'($urandom), ($urandom_range(0, 99) < 60));
      checks++;
      if (OCC !== 2'(mq.size()) || QV !== (mq.size() > 0) ||
          DR !== ((mq.size() < 2) && !RST) || QN !== ~Q ||
          (mq.size() > 0 && Q !== mq[0]) || (mq.size() == 0 && m_zero && Q !== '0)) begin
        failures++; errs++;
        if (errs <= 10)
          $display("FAIL rand_cycle n=%0d occ=%0d qv=%b dr=%b q=%h exp occ=%0d head=%h",
                   n, OCC, QV, DR, Q, mq.size(), (mq.size() > 0) ? mq[0] : '0);
      end
    end
    RST = 1'b0; FLUSH = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 1);
    checks++; if (dut_popped.size() != exp_popped.size()) begin
      failures++; $display("FAIL rand_count got=%0d exp=%0d", dut_popped.size(), exp_popped.size());
    end else begin
      for (int i = 0; i < exp_popped.size(); i++) begin
        if (dut_popped[i] !== exp_popped[i]) begin
          failures++; $display("FAIL rand_order idx=%0d got=%h exp=%h", i, dut_popped[i], exp_popped[i]);
          break;
        end
      end
    end
    clear_logs();
  endtask

  initial begin
    #1;
    test_reset();
    test_single_pass();
    test_stall_fill();
    test_streaming();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gtech_skid_buf.md
Name: gtech_skid_buf

Overview:
- Two-entry valid/ready skid buffer that sits directly upstream of the GTECH flop stage and feeds it registered data and complement outputs.
- Decouples the producer's handshake from the consumer's stall timing.
- Sustains one word per cycle with no combinational path from QR to DR.
- Provides Q/QN output pairs matching the flop-primitive convention so downstream register banks connect directly.

Parameters:
- WIDTH, 8, data word width in bits (>=1).

Ports:
- CP  input  1  clock; all state changes on posedge CP.
- RST  input  1  synchronous active-high reset.
- FLUSH  input  1  synchronous discard of all buffered words.
- D  input  WIDTH  upstream data.
- DV  input  1  upstream data valid.
- DR  output  1  ready to upstream.
- Q  output  WIDTH  head-of-buffer data.
- QN  output  WIDTH  bitwise complement of Q, always.
- QV  output  1  Q valid to downstream.
- QR  input  1  downstream ready.
- OCC  output  2  occupancy, 0..2.

Behaviour:
- Storage: main register (drives Q) and skid register. State encoded as OCC:
  - EMPTY = 0
  - ONE = 1
  - FULL = 2
- Push = DV & DR. Pop = QV & QR. Both are evaluated at posedge CP.
- DR = (OCC != 2) & !RST. It is driven from state only and has no dependence on QR or DV.
- QV = (OCC != 0), derived from state.
- QN = ~Q combinationally at all times, including during reset.
- Reset:
  - RST high at posedge CP sets OCC=0, main=0, skid=0.
  - After reset: Q=0, QN=all ones, QV=0, DR=1, OCC=0.
  - RST has priority over FLUSH and over all handshakes.
  - Mid-operation reset silently drops the buffered words.
- Flush:
  - FLUSH high (RST low) sets OCC=0 and main=0. The skid register contents are don't-care.
  - Any push in that cycle is discarded.
  - A pop in that cycle completes from the downstream's view: the word was presented and taken.
- Transitions (RST=FLUSH=0):
  - EMPTY, push: main<=D, go to ONE.
  - EMPTY, no push: stay. Pop is impossible because QV=0.
  - ONE, push and pop: main<=D, stay ONE.
  - ONE, push only: skid<=D, go to FULL.
  - ONE, pop only: go to EMPTY. main holds its value; Q is don't-care while QV=0.
  - ONE, neither: hold.
  - FULL, pop: main<=skid, go to ONE. Push is impossible because DR=0.
  - FULL, no pop: hold. Q stable, QV=1.
- Latency: a word accepted at edge N is presented on Q with QV=1 after edge N (one cycle) when the buffer was EMPTY, or when it was ONE with a simultaneous pop.
- Ordering: strict FIFO; no word is duplicated or lost except by RST or FLUSH.
- Stability: while QV=1 and QR=0, Q must not change.
- Throughput: continuous DV=1 and QR=1 yields one word per cycle at OCC=1.

Test Plan:
1. Reset: RST=1 for 2 cycles with DV=1, D=8'hAA -> after release Q=8'h00, QN=8'hFF, QV=0, DR=1, OCC=0; no word emitted.
2. Single pass: push 8'h3C at edge N with QR=1 -> Q=8'h3C, QN=8'hC3, QV=1 after edge N; popped at edge N+1 -> OCC=0, QV=0.
3. Stall fill:
   - QR=0; push 8'h11, 8'h22, then offer 8'h33.
   - Required: OCC=2 and DR=0 after the 2nd push; Q holds 8'h11; 8'h33 is not accepted.
   - Then QR=1: outputs 8'h11, 8'h22, then 8'h33 in order.
4. Streaming: DV=QR=1 for 16 cycles with D=0..15 -> Q sequence 0..15, one per cycle, OCC stays 1, DR stays 1.
5. Flush: OCC=2 holding 8'h55, 8'h66; FLUSH=1 with DV=1, D=8'h77 -> next cycle OCC=0, QV=0, Q=8'h00; 8'h77 is never output.
6. Reset mid-stream: assert RST while OCC=2 and DV=1 -> next cycle OCC=0, QV=0; no pre-reset word appears after release.
